// File: rtl/rob_commit.sv
// Purpose : in-order commit buffer; allocates tags at dispatch, absorbs out-of-order completions, retires one entry per cycle to the RF write port.
// Latency : completion sampled at edge E -> earliest commit at edge E+1 -> wr high for the cycle after E+1.
// Backpressure: alloc_ready drops when all DEPTH entries are occupied; completions and RF writes are never stalled.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-low reset
//   flush             discard every entry (wins over alloc, completion and commit)
//   alloc_valid/_rd   dispatch request and its destination register
//   alloc_ready/_tag  not-full indication and the tag (tail index) handed to dispatch
//   cmp_valid/_tag/_data  out-of-order result report by tag
//   wr, wd            registered RF write enable / write-data valid (identical)
//   write_reg/_data   registered RF write index (zero-extended) and value
//   count, empty      occupancy
module rob_commit #(
    parameter int BITWIDTH = 32,
    parameter int DEPTH    = 8,
    parameter int TAGW     = 3,
    parameter int REGADDR  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                alloc_valid,
    input  logic [REGADDR-1:0]  alloc_rd,
    output logic                alloc_ready,
    output logic [TAGW-1:0]     alloc_tag,
    input  logic                cmp_valid,
    input  logic [TAGW-1:0]     cmp_tag,
    input  logic [BITWIDTH-1:0] cmp_data,
    output logic                wr,
    output logic                wd,
    output logic [BITWIDTH-1:0] write_reg,
    output logic [BITWIDTH-1:0] write_data,
    output logic [TAGW:0]       count,
    output logic                empty
);

    // Per-entry state. busy/done are reset; the payload is only ever read
    // when the matching busy/done bits are set, so it carries no reset.
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [DEPTH-1:0]    done_q, done_d;
    logic [REGADDR-1:0]  rd_q   [DEPTH];
    logic [REGADDR-1:0]  rd_d   [DEPTH];
    logic [BITWIDTH-1:0] data_q [DEPTH];
    logic [BITWIDTH-1:0] data_d [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [TAGW:0]       head_q, head_d;
    logic [TAGW:0]       tail_q, tail_d;

    // Registered RF write port.
    logic                wr_q, wr_d;
    logic [BITWIDTH-1:0] write_reg_q, write_reg_d;
    logic [BITWIDTH-1:0] write_data_q, write_data_d;

    logic [TAGW-1:0]     head_idx;
    logic [TAGW-1:0]     tail_idx;
    logic                full;
    logic                do_alloc;
    logic                do_cmp;
    logic                commit;
    logic                head_has_dest;

    assign head_idx = head_q[TAGW-1:0];
    assign tail_idx = tail_q[TAGW-1:0];

    assign full  = (head_idx == tail_idx) && (head_q[TAGW] != tail_q[TAGW]);
    assign empty = (head_q == tail_q);
    assign count = tail_q - head_q;

    // alloc_ready deliberately ignores a same-cycle commit: a full buffer
    // refuses dispatch for one cycle even if the head is about to retire.
    assign alloc_ready = !full;
    assign alloc_tag   = tail_idx;

    assign do_alloc = alloc_valid && !full && !flush;
    assign do_cmp   = cmp_valid && busy_q[cmp_tag] && !flush;
    assign commit   = busy_q[head_idx] && done_q[head_idx] && !flush;

    // Register 0 is hard-wired in the RF; such entries retire without a write.
    assign head_has_dest = (rd_q[head_idx] != '0);

    always_comb begin
        busy_d       = busy_q;
        done_d       = done_q;
        rd_d         = rd_q;
        data_d       = data_q;
        head_d       = head_q;
        tail_d       = tail_q;
        // Idle outputs must be all-zero: the RF bypass matches on write_reg
        // without looking at wr.
        wr_d         = 1'b0;
        write_reg_d  = '0;
        write_data_d = '0;

        if (flush) begin
            busy_d = '0;
            done_d = '0;
            head_d = '0;
            tail_d = '0;
        end else begin
            // Completion first; a repeated completion simply overwrites data.
            if (do_cmp) begin
                done_d[cmp_tag] = 1'b1;
                data_d[cmp_tag] = cmp_data;
            end

            // Commit uses pre-edge state only, so a completion landing on the
            // head this cycle is retired on the following edge. The clear
            // below is ordered after the completion so a duplicate completion
            // to a retiring head cannot resurrect it.
            if (commit) begin
                busy_d[head_idx] = 1'b0;
                done_d[head_idx] = 1'b0;
                head_d           = head_q + 1'b1;
                if (head_has_dest) begin
                    wr_d         = 1'b1;
                    write_reg_d  = BITWIDTH'(rd_q[head_idx]);
                    write_data_d = data_q[head_idx];
                end
            end

            // The tail slot is never the committing head: allocation is
            // blocked when full, and an empty buffer has nothing to commit.
            if (do_alloc) begin
                busy_d[tail_idx] = 1'b1;
                done_d[tail_idx] = 1'b0;
                rd_d[tail_idx]   = alloc_rd;
                tail_d           = tail_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q       <= '0;
            done_q       <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            wr_q         <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            busy_q       <= busy_d;
            done_q       <= done_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            wr_q         <= wr_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    assign wr         = wr_q;
    assign wd         = wr_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

endmodule

// File: tb/tb_rob_commit.sv
// Purpose : self-checking bench for rob_commit against a queue-based reference.
// Latency : every cycle compares all DUT outputs with the reference before the edge.
// Backpressure: the reference refuses allocations when it holds DEPTH entries.
module tb_rob_commit;

    localparam int BW    = 32;
    localparam int DEPTH = 8;
    localparam int TAGW  = 3;
    localparam int RA    = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            alloc_valid;
    logic [RA-1:0]   alloc_rd;
    logic            alloc_ready;
    logic [TAGW-1:0] alloc_tag;
    logic            cmp_valid;
    logic [TAGW-1:0] cmp_tag;
    logic [BW-1:0]   cmp_data;
    logic            wr;
    logic            wd;
    logic [BW-1:0]   write_reg;
    logic [BW-1:0]   write_data;
    logic [TAGW:0]   count;
    logic            empty;

    always #5 clk = ~clk;

    rob_commit #(
        .BITWIDTH (BW),
        .DEPTH    (DEPTH),
        .TAGW     (TAGW),
        .REGADDR  (RA)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .alloc_ready (alloc_ready),
        .alloc_tag   (alloc_tag),
        .cmp_valid   (cmp_valid),
        .cmp_tag     (cmp_tag),
        .cmp_data    (cmp_data),
        .wr          (wr),
        .wd          (wd),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .count       (count),
        .empty       (empty)
    );

    // Reference: program-order queue of in-flight instructions. Queue slot i
    // holds tag (head_ptr + i) mod DEPTH.
    typedef struct {
        logic [RA-1:0] rd;
        bit            done;
        logic [BW-1:0] data;
    } ent_t;

    ent_t          q[$];
    int            head_ptr;
    logic          m_wr;
    logic [BW-1:0] m_reg;
    logic [BW-1:0] m_data;

    int checks  = 0;
    int errors  = 0;
    int wr_seen = 0;
    int max_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        head_ptr = 0;
        m_wr     = 1'b0;
        m_reg    = '0;
        m_data   = '0;
    endtask

    function automatic int next_tag();
        return (head_ptr + q.size()) % DEPTH;
    endfunction

    // One clock cycle: drive inputs, compare every output with the reference,
    // advance the reference, then cross the rising edge.
    task automatic cyc(input logic r, input logic f, input logic av, input logic [RA-1:0] ard,
                       input logic cv, input logic [TAGW-1:0] ct, input logic [BW-1:0] cd);
        int   idx;
        int   sz;
        bit   com;
        ent_t h;
        rst         = r;
        flush       = f;
        alloc_valid = av;
        alloc_rd    = ard;
        cmp_valid   = cv;
        cmp_tag     = ct;
        cmp_data    = cd;
        #2;
        sz = q.size();
        chk("alloc_ready", 64'(alloc_ready), 64'(sz < DEPTH));
        chk("alloc_tag",   64'(alloc_tag),   64'(next_tag()));
        chk("count",       64'(count),       64'(sz));
        chk("empty",       64'(empty),       64'(sz == 0));
        chk("wr",          64'(wr),          64'(m_wr));
        chk("wd",          64'(wd),          64'(m_wr));
        chk("write_reg",   64'(write_reg),   64'(m_reg));
        chk("write_data",  64'(write_data),  64'(m_data));
        if (wr === 1'b1) wr_seen++;
        if (int'(count) > max_cnt) max_cnt = int'(count);

        if (!r || f) begin
            model_reset();
        end else begin
            com = (sz > 0) && q[0].done;
            h   = '{rd: '0, done: 1'b0, data: '0};
            if (com) h = q[0];
            if (cv) begin
                idx = (int'(ct) - head_ptr) & (DEPTH - 1);
                if (idx < sz) begin
                    q[idx].done = 1'b1;
                    q[idx].data = cd;
                end
            end
            if (com) begin
                void'(q.pop_front());
                head_ptr = (head_ptr + 1) % (2 * DEPTH);
                m_wr     = (h.rd != '0);
                m_reg    = m_wr ? BW'(h.rd) : '0;
                m_data   = m_wr ? h.data : '0;
            end else begin
                m_wr   = 1'b0;
                m_reg  = '0;
                m_data = '0;
            end
            if (av && sz < DEPTH) q.push_back('{rd: ard, done: 1'b0, data: '0});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic alloc(input logic [RA-1:0] rd);
        cyc(1'b1, 1'b0, 1'b1, rd, 1'b0, '0, '0);
    endtask

    task automatic complete(input logic [TAGW-1:0] t, input logic [BW-1:0] d);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, t, d);
    endtask

    initial begin
        logic [TAGW-1:0] prev_tag;
        bit              prev_vld;
        logic [TAGW-1:0] rt;

        rst = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_rd = '0;
        cmp_valid = 1'b0; cmp_tag = '0; cmp_data = '0;
        @(posedge clk);
        #1;
        model_reset();

        // Out-of-order completion, in-order retire on consecutive cycles.
        do_reset();
        alloc(5'd5);
        alloc(5'd7);
        complete(3'd1, 32'hBBBB_BBBB);
        complete(3'd0, 32'hAAAA_AAAA);
        wr_seen = 0;
        idle(5);
        chk("two_writes", 64'(wr_seen), 64'd2);

        // Fill to capacity, refused 9th allocation, wrap of the tag.
        do_reset();
        for (int k = 0; k < DEPTH; k++) alloc(RA'(k + 1));
        alloc(5'd20);
        chk("full_count", 64'(count), 64'd8);
        chk("full_ready", 64'(alloc_ready), 64'd0);
        complete(3'd0, 32'h0000_0010);
        idle(1);
        chk("after_commit_ready", 64'(alloc_ready), 64'd1);
        chk("after_commit_tag", 64'(alloc_tag), 64'd0);
        chk("after_commit_count", 64'(count), 64'd7);
        alloc(5'd9);
        for (int k = 1; k <= DEPTH; k++) complete(TAGW'(k % DEPTH), 32'hC000_0000 + 32'(k));
        idle(10);

        // Destination r0 retires silently.
        do_reset();
        alloc(5'd0);
        complete(3'd0, 32'h0000_1234);
        wr_seen = 0;
        idle(3);
        chk("r0_count", 64'(count), 64'd0);
        chk("r0_no_write", 64'(wr_seen), 64'd0);
        chk("r0_write_data", 64'(write_data), 64'd0);

        // Streaming: each allocation completed the following cycle.
        do_reset();
        wr_seen  = 0;
        max_cnt  = 0;
        prev_vld = 1'b0;
        prev_tag = '0;
        for (int k = 0; k < 20; k++) begin
            rt = TAGW'(next_tag());
            cyc(1'b1, 1'b0, 1'b1, RA'((k % 31) + 1), prev_vld, prev_tag, 32'h5000_0000 + 32'(k));
            prev_vld = 1'b1;
            prev_tag = rt;
        end
        complete(prev_tag, 32'h5000_00FF);
        idle(4);
        chk("stream_writes", 64'(wr_seen), 64'd20);
        chk("stream_max_count", 64'(max_cnt <= 2), 64'd1);

        // Flush discards everything; a stale completion afterwards is ignored.
        do_reset();
        for (int k = 0; k < 4; k++) alloc(RA'(k + 10));
        complete(3'd1, 32'h0000_0111);
        complete(3'd2, 32'h0000_0222);
        cyc(1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 3'd0, 32'hDEAD_BEEF);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        wr_seen = 0;
        complete(3'd1, 32'h0000_0333);
        idle(4);
        chk("flush_no_write", 64'(wr_seen), 64'd0);

        // Reset in the cycle the head would commit.
        do_reset();
        for (int k = 0; k < 3; k++) alloc(RA'(k + 3));
        complete(3'd2, 32'h0000_0002);
        complete(3'd1, 32'h0000_0001);
        complete(3'd0, 32'h0000_0000);
        do_reset();
        chk("rst_wr", 64'(wr), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(alloc_ready), 64'd1);
        wr_seen = 0;
        idle(4);
        chk("rst_no_write", 64'(wr_seen), 64'd0);

        // Randomised traffic with occasional flush and reset.
        do_reset();
        for (int k = 0; k < 800; k++) begin
            logic          r;
            logic          f;
            logic          av;
            logic [RA-1:0] rd;
            logic          cv;
            logic [TAGW-1:0] ct;
            r  = ($urandom_range(0, 199) != 0);
            f  = ($urandom_range(0, 59) == 0);
            av = ($urandom_range(0, 2) != 0);
            rd = ($urandom_range(0, 6) == 0) ? '0 : RA'($urandom);
            cv = ($urandom_range(0, 1) == 1);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                ct = TAGW'((head_ptr + $urandom_range(0, q.size() - 1)) % DEPTH);
            else
                ct = TAGW'($urandom);
            cyc(r, f, av, rd, cv, ct, $urandom);
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
